// File: rtl/ula_serial_nibble.sv
// Serial WIDTH-bit ALU: one 74181-style nibble slice, one nibble per clock.
// Ports: clk, rst, start, a, b, s, m, c_in -> busy, done, f, c_out, a_eq_b.

module ula_74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       c_ripple,
  output logic       a_eq_b
);

  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] lg;
  logic [4:0] sum;

  // Arithmetic is X plus Y plus true carry; "minus 1" terms add 4'hF.
  always_comb begin
    x  = 4'h0;
    y  = 4'h0;
    lg = 4'h0;
    case (s)
      4'b0000: begin x = a;       y = 4'hF;    lg = ~a;       end
      4'b0001: begin x = a & b;   y = 4'hF;    lg = ~(a & b); end
      4'b0010: begin x = a & ~b;  y = 4'hF;    lg = ~a | b;   end
      4'b0011: begin x = 4'hF;    y = 4'h0;    lg = 4'hF;     end
      4'b0100: begin x = a;       y = a | ~b;  lg = ~(a | b); end
      4'b0101: begin x = a & b;   y = a | ~b;  lg = ~b;       end
      4'b0110: begin x = a;       y = ~b;      lg = ~(a ^ b); end
      4'b0111: begin x = a | ~b;  y = 4'h0;    lg = a | ~b;   end
      4'b1000: begin x = a;       y = a | b;   lg = ~a & b;   end
      4'b1001: begin x = a;       y = b;       lg = a ^ b;    end
      4'b1010: begin x = a & ~b;  y = a | b;   lg = b;        end
      4'b1011: begin x = a | b;   y = 4'h0;    lg = a | b;    end
      4'b1100: begin x = a;       y = a;       lg = 4'h0;     end
      4'b1101: begin x = a & b;   y = a;       lg = a & ~b;   end
      4'b1110: begin x = a & ~b;  y = a;       lg = a & b;    end
      default: begin x = a;       y = 4'h0;    lg = a;        end
    endcase
  end

  assign sum      = {1'b0, x} + {1'b0, y} + {4'b0, c_in};
  assign f        = m ? lg : sum[3:0];
  assign c_ripple = m ? 1'b0 : sum[4];
  assign a_eq_b   = (a == b);

endmodule

module ula_serial_nibble #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             a_eq_b
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry_r;
  logic             eq_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       s_r;
  logic             m_r;

  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  logic [3:0]       sl_f;
  logic             sl_c;
  logic             sl_eq;
  logic [WIDTH-1:0] acc_nx;

  assign sl_a = a_r[idx*4 +: 4];
  assign sl_b = b_r[idx*4 +: 4];

  ula_74181 u_slice (
    .a        (sl_a),
    .b        (sl_b),
    .s        (s_r),
    .m        (m_r),
    .c_in     (carry_r),
    .f        (sl_f),
    .c_ripple (sl_c),
    .a_eq_b   (sl_eq)
  );

  // Accumulator with the current nibble merged in, so the last
  // nibble lands in f on the same edge as the rest.
  always_comb begin
    acc_nx = acc;
    acc_nx[idx*4 +: 4] = sl_f;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry_r <= 1'b0;
      eq_r    <= 1'b0;
      acc     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      s_r     <= 4'h0;
      m_r     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      f       <= '0;
      c_out   <= 1'b0;
      a_eq_b  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            s_r     <= s;
            m_r     <= m;
            idx     <= '0;
            carry_r <= c_in;
            eq_r    <= 1'b1;
            acc     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state   <= IDLE;
          end
        end
        RUN: begin
          acc     <= acc_nx;
          carry_r <= sl_c;
          eq_r    <= eq_r & sl_eq;
          idx     <= idx + IW'(1);
          if (idx == LAST) begin
            f      <= acc_nx;
            c_out  <= sl_c & ~m_r;
            a_eq_b <= eq_r & sl_eq;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_serial_nibble.sv
// Self-checking bench for ula_serial_nibble (WIDTH 8 and 16 instances).
// Table vectors plus control corner sequences, scoreboard queue of results.

module tb_ula_serial_nibble;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] s8 = '0;
  logic       m8 = 1'b0, ci8 = 1'b0;
  logic       busy8, done8, co8, eq8;
  logic [7:0] f8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  s16 = '0;
  logic        m16 = 1'b0, ci16 = 1'b0;
  logic        busy16, done16, co16, eq16;
  logic [15:0] f16;

  ula_serial_nibble #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .s(s8),
    .m(m8), .c_in(ci8), .busy(busy8), .done(done8), .f(f8),
    .c_out(co8), .a_eq_b(eq8)
  );

  ula_serial_nibble #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .s(s16),
    .m(m16), .c_in(ci16), .busy(busy16), .done(done16), .f(f16),
    .c_out(co16), .a_eq_b(eq16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
    logic       m;
    logic       ci;
    logic [7:0] f;
    logic       co;
    logic       eq;
  } vec_t;

  typedef struct {
    logic [7:0] f;
    logic       co;
    logic       eq;
  } exp_t;

  exp_t q8[$];
  logic [16:0] q16[$];
  vec_t vecs[11];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic drive8(input vec_t v);
    exp_t e;
    a8 = v.a; b8 = v.b; s8 = v.s; m8 = v.m; ci8 = v.ci;
    start8 = 1'b1;
    e.f = v.f; e.co = v.co; e.eq = v.eq;
    q8.push_back(e);
  endtask

  task automatic wait_done8(input string nm, input int lat, input bit drop);
    int k;
    bit seen;
    exp_t e;
    k = 0;
    seen = 0;
    if (drop) begin
      @(posedge clk);
      #1 start8 = 1'b0;
    end
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (done8) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got=no_done expected=done", nm);
    end else if (q8.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got=unexpected_done expected=none", nm);
    end else begin
      e = q8.pop_front();
      chk({nm, "_lat"}, k, lat);
      chk({nm, "_f"}, {24'h0, f8}, {24'h0, e.f});
      chk({nm, "_co"}, {31'h0, co8}, {31'h0, e.co});
      chk({nm, "_eq"}, {31'h0, eq8}, {31'h0, e.eq});
    end
  endtask

  initial begin
    int nd;
    int k;
    int nb;
    bit seen;
    logic [16:0] e16;

    vecs[0]  = '{8'h3C, 8'h55, 4'b1001, 1'b0, 1'b0, 8'h91, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 4'b1001, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'h50, 8'h20, 4'b0110, 1'b0, 1'b1, 8'h30, 1'b1, 1'b0};
    vecs[3]  = '{8'h20, 8'h50, 4'b0110, 1'b0, 1'b1, 8'hD0, 1'b0, 1'b0};
    vecs[4]  = '{8'hA5, 8'h0F, 4'b1001, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0};
    vecs[5]  = '{8'h77, 8'h77, 4'b1110, 1'b1, 1'b0, 8'h77, 1'b0, 1'b1};
    vecs[6]  = '{8'h12, 8'h12, 4'b1001, 1'b0, 1'b1, 8'h25, 1'b0, 1'b1};
    vecs[7]  = '{8'h3C, 8'h00, 4'b0000, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0};
    vecs[8]  = '{8'hFF, 8'h00, 4'b1111, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[10] = '{8'hF0, 8'h0F, 4'b0110, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy8}, 32'h0);
    chk("rst_done", {31'h0, done8}, 32'h0);
    chk("rst_f", {24'h0, f8}, 32'h0);
    chk("rst_co", {31'h0, co8}, 32'h0);
    chk("rst_eq", {31'h0, eq8}, 32'h0);
    chk("rst_f16", {16'h0, f16}, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive8(vecs[i]);
      @(posedge clk);
      #1 start8 = 1'b0;
      chk($sformatf("v%0d_busy", i), {31'h0, busy8}, 32'h1);
      wait_done8($sformatf("v%0d", i), 3, 0);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {31'h0, done8}, 32'h0);
      chk($sformatf("v%0d_idle", i), {31'h0, busy8}, 32'h0);
    end

    // start re-pulsed during RUN with other operands must be ignored
    @(negedge clk);
    drive8(vecs[0]);
    @(posedge clk);
    #1 start8 = 1'b0;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; s8 = 4'b0011; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    wait_done8("repulse", 2, 0);
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (done8) nd++;
    end
    chk("repulse_extra_done", nd, 0);

    // start held high through DONE: back-to-back operation
    @(negedge clk);
    drive8(vecs[1]);
    wait_done8("b2b_first", 3, 0);
    drive8(vecs[2]);
    @(posedge clk);
    #1 start8 = 1'b0;
    chk("b2b_done_drop", {31'h0, done8}, 32'h0);
    chk("b2b_busy", {31'h0, busy8}, 32'h1);
    wait_done8("b2b_second", 3, 0);

    // reset after E1 aborts the operation
    @(negedge clk);
    drive8(vecs[4]);
    @(posedge clk);
    #1 start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'h0, busy8}, 32'h0);
    chk("abort_f", {24'h0, f8}, 32'h0);
    chk("abort_done", {31'h0, done8}, 32'h0);
    q8.delete();
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done8) nd++;
    end
    chk("abort_no_done", nd, 0);

    // 16-bit instance: four RUN cycles, carry ripples over three nibbles
    @(negedge clk);
    a16 = 16'h0FFF; b16 = 16'h0001; s16 = 4'b1001; m16 = 1'b0; ci16 = 1'b0;
    start16 = 1'b1;
    q16.push_back({1'b0, 16'h1000});
    @(posedge clk);
    #1 start16 = 1'b0;
    k = 0;
    nb = 0;
    seen = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (busy16) nb++;
      if (done16) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL w16 timeout got=no_done expected=done");
    end else begin
      e16 = q16.pop_front();
      chk("w16_lat", k, 5);
      chk("w16_busy_cycles", nb, 4);
      chk("w16_f", {16'h0, f16}, {16'h0, e16[15:0]});
      chk("w16_co", {31'h0, co16}, {31'h0, e16[16]});
      chk("w16_eq", {31'h0, eq16}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
